gpr_xfer_ctrl: RTL and testbench

Command-driven initiator for the 8-entry general-purpose register file. It sits on the file's access port, between the decode/sequencer and the register file. It accepts one transfer command at a time over a valid/ready handshake: MOV, LDI (load immediate), SWAP or RD (read-out). It sequences the single-port read_en/write_en/reg_num accesses, including the file's one-cycle registered read latency, and reports completion with a one-cycle response pulse.

---
 rtl/gpr_xfer_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_gpr_xfer_ctrl.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_xfer_ctrl.sv
// gpr_xfer_ctrl: command-driven initiator for the 8-entry register file.
// Accepts MOV / LDI / SWAP / RD commands one at a time and sequences the
// single-port read/write accesses, including the one-cycle registered read
// latency of the file, then reports completion with a one-cycle pulse.
//
// Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is high only while the controller is IDLE; cmd_valid outside that
// window is ignored and nothing is queued. rsp_valid is a single-cycle pulse
// with no backpressure, one per completed command.
module gpr_xfer_ctrl #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [REG_AW-1:0] cmd_src,
    input  logic [REG_AW-1:0] cmd_dst,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              read_en,
    output logic              write_en,
    output logic [REG_AW-1:0] reg_num,
    output logic [DATA_W-1:0] writeToReg,
    input  logic [DATA_W-1:0] readFromReg,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        CAP_A = 3'd2,
        RD_B  = 3'd3,
        CAP_B = 3'd4,
        WR_A  = 3'd5,
        WR_B  = 3'd6,
        DONE  = 3'd7
    } state_t;

    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_LDI  = 2'b01;
    localparam logic [1:0] OP_SWAP = 2'b10;
    localparam logic [1:0] OP_RD   = 2'b11;

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [REG_AW-1:0]   src_q, src_d;
    logic [REG_AW-1:0]   dst_q, dst_d;
    logic [DATA_W-1:0]   tmp_a_q, tmp_a_d;
    logic [DATA_W-1:0]   tmp_b_q, tmp_b_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                read_en_q, read_en_d;
    logic                write_en_q, write_en_d;
    logic [REG_AW-1:0]   reg_num_q, reg_num_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    // Next state, command latch, temp capture, and output decode from the next state
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        src_d       = src_q;
        dst_d       = dst_q;
        tmp_a_d     = tmp_a_q;
        tmp_b_d     = tmp_b_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d  = cmd_op;
                    src_d = cmd_src;
                    dst_d = cmd_dst;
                    if (cmd_op == OP_LDI) begin
                        // The immediate travels through tmpA so WR_A is op-agnostic
                        tmp_a_d = cmd_imm;
                        state_d = WR_A;
                    end else begin
                        state_d = RD_A;
                    end
                end
            end
            RD_A:  state_d = CAP_A;
            CAP_A: begin
                // Read data for the RD_A access is valid in this cycle
                tmp_a_d = readFromReg;
                case (op_q)
                    OP_RD:   state_d = DONE;
                    OP_SWAP: state_d = RD_B;
                    default: state_d = WR_A;
                endcase
            end
            RD_B:  state_d = CAP_B;
            CAP_B: begin
                tmp_b_d = readFromReg;
                state_d = WR_A;
            end
            WR_A:  state_d = (op_q == OP_SWAP) ? WR_B : DONE;
            WR_B:  state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so decode them from the state being entered.
        // reg_num / writeToReg / rsp_data hold their values when not driven.
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        read_en_d   = 1'b0;
        write_en_d  = 1'b0;
        reg_num_d   = reg_num_q;
        wdata_d     = wdata_q;
        rsp_data_d  = rsp_data_q;

        case (state_d)
            IDLE: cmd_ready_d = 1'b1;
            RD_A: begin
                read_en_d = 1'b1;
                reg_num_d = src_d;
            end
            RD_B: begin
                read_en_d = 1'b1;
                reg_num_d = dst_d;
            end
            WR_A: begin
                write_en_d = 1'b1;
                reg_num_d  = dst_d;
                wdata_d    = tmp_a_d;
            end
            WR_B: begin
                write_en_d = 1'b1;
                reg_num_d  = src_d;
                wdata_d    = tmp_b_d;
            end
            DONE: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = tmp_a_d;
            end
            default: ;
        endcase
    end

    // State, latched command, temps and registered outputs; async reset aborts any command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= 2'b00;
            src_q       <= '0;
            dst_q       <= '0;
            tmp_a_q     <= '0;
            tmp_b_q     <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            read_en_q   <= 1'b0;
            write_en_q  <= 1'b0;
            reg_num_q   <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            tmp_a_q     <= tmp_a_d;
            tmp_b_q     <= tmp_b_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            read_en_q   <= read_en_d;
            write_en_q  <= write_en_d;
            reg_num_q   <= reg_num_d;
            wdata_q     <= wdata_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign read_en    = read_en_q;
    assign write_en   = write_en_q;
    assign reg_num    = reg_num_q;
    assign writeToReg = wdata_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_gpr_xfer_ctrl.sv
// Bench for gpr_xfer_ctrl: a behavioural register file on the access port,
// a command-level reference model, and scenario tasks run in sequence.
module tb_gpr_xfer_ctrl;
    localparam int DATA_W = 8;
    localparam int REG_AW = 3;
    localparam int NREG   = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'b00;
    logic [REG_AW-1:0] cmd_src = '0;
    logic [REG_AW-1:0] cmd_dst = '0;
    logic [DATA_W-1:0] cmd_imm = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              read_en;
    logic              write_en;
    logic [REG_AW-1:0] reg_num;
    logic [DATA_W-1:0] writeToReg;
    logic [DATA_W-1:0] readFromReg;
    logic [2:0]        dbg_state;

    gpr_xfer_ctrl #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .read_en(read_en), .write_en(write_en), .reg_num(reg_num),
        .writeToReg(writeToReg), .readFromReg(readFromReg),
        .dbg_state(dbg_state)
    );

    // ---------------- register file (environment) ----------------
    logic [DATA_W-1:0] rf [NREG] = '{default: 8'h00};
    logic [DATA_W-1:0] rd_q = 8'h00;
    always @(posedge clk) begin
        if (write_en) rf[reg_num] <= writeToReg;
        if (read_en)  rd_q <= rf[reg_num];
    end
    assign readFromReg = rd_q;

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [DATA_W-1:0] ref_rf [NREG] = '{default: 8'h00};
    logic [DATA_W-1:0] exp_q[$];

    int          exp_lat;
    logic [7:0]  exp_data;
    int          exp_rd_n, exp_wr_n;
    logic [15:0] exp_rd_sig;
    logic [31:0] exp_wr_sig;

    int          rsp_cnt, rsp_at;
    logic [7:0]  rsp_dat;
    int          obs_rd_n, obs_wr_n;
    logic [15:0] obs_rd_sig;
    logic [31:0] obs_wr_sig;
    bit          busy_bad, ready_after;
    logic        cyc_re [16];
    logic        cyc_we [16];
    logic [2:0]  cyc_rn [16];
    logic [7:0]  cyc_wd [16];

    // Continuous protocol monitor
    logic rv_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            n_tests++;
            if (read_en && write_en) begin
                n_fail++;
                $display("FAIL excl_en: read_en=%0b write_en=%0b, must not both be 1", read_en, write_en);
            end
            n_tests++;
            if (rsp_valid && rv_prev) begin
                n_fail++;
                $display("FAIL rsp_pulse: rsp_valid high 2 cycles in a row, want single pulse");
            end
        end
        rv_prev = rsp_valid;
    end

    // Watchdog
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Command-level effect: latency, response value, accesses in order, file update
    task automatic model_cmd(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                             input logic [7:0] imm);
        logic [7:0] a, b;
        a = ref_rf[src];
        b = ref_rf[dst];
        exp_rd_n = 0; exp_rd_sig = '0; exp_wr_n = 0; exp_wr_sig = '0;
        case (op)
            2'b00: begin // MOV
                exp_lat = 4; exp_data = a;
                exp_rd_n = 1; exp_rd_sig = {13'd0, src};
                exp_wr_n = 1; exp_wr_sig = {21'd0, dst, a};
                ref_rf[dst] = a;
            end
            2'b01: begin // LDI
                exp_lat = 2; exp_data = imm;
                exp_wr_n = 1; exp_wr_sig = {21'd0, dst, imm};
                ref_rf[dst] = imm;
            end
            2'b10: begin // SWAP
                exp_lat = 7; exp_data = a;
                exp_rd_n = 2; exp_rd_sig = {10'd0, src, dst};
                exp_wr_n = 2; exp_wr_sig = {10'd0, dst, a, src, b};
                ref_rf[dst] = a;
                ref_rf[src] = b;
            end
            default: begin // RD
                exp_lat = 3; exp_data = a;
                exp_rd_n = 1; exp_rd_sig = {13'd0, src};
            end
        endcase
        exp_q.push_back(exp_data);
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge; issues one command and records the
    // cycles 1..lat+1 after its acceptance edge.
    task automatic run_cmd(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                           input logic [7:0] imm, input bit hold);
        int waited;
        model_cmd(op, src, dst, imm);
        rsp_cnt = 0; rsp_at = 0; rsp_dat = '0;
        obs_rd_n = 0; obs_rd_sig = '0; obs_wr_n = 0; obs_wr_sig = '0;
        busy_bad = 1'b0; ready_after = 1'b0;
        for (int k = 0; k < 16; k++) begin
            cyc_re[k] = 1'b0; cyc_we[k] = 1'b0; cyc_rn[k] = '0; cyc_wd[k] = '0;
        end
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (cmd_ready !== 1'b1) begin
            cmd_valid = 1'b0;
            return;
        end
        cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_imm = imm;
        cmd_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= exp_lat + 1; k++) begin
            @(negedge clk);
            cyc_re[k] = read_en; cyc_we[k] = write_en;
            cyc_rn[k] = reg_num; cyc_wd[k] = writeToReg;
            if (read_en) begin
                obs_rd_n++;
                obs_rd_sig = {obs_rd_sig[12:0], reg_num};
            end
            if (write_en) begin
                obs_wr_n++;
                obs_wr_sig = {obs_wr_sig[20:0], reg_num, writeToReg};
            end
            if (rsp_valid) begin
                rsp_cnt++;
                if (rsp_cnt == 1) begin
                    rsp_at = k;
                    rsp_dat = rsp_data;
                end
            end
            if (k <= exp_lat && cmd_ready !== 1'b0) busy_bad = 1'b1;
            if (k == exp_lat + 1) ready_after = (cmd_ready === 1'b1);
            if (k == 1 && !hold) cmd_valid = 1'b0;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", cmd_ready); end
        n_tests++;
        if ({rsp_valid, read_en, write_en} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes: rsp/rd/wr got %03b want 000", {rsp_valid, read_en, write_en});
        end
        n_tests++;
        if (reg_num !== 3'd0 || writeToReg !== 8'h00) begin
            n_fail++; $display("FAIL reset_rf_side: reg_num=%0d wdata=%02h want 0/00", reg_num, writeToReg);
        end
        n_tests++;
        if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_data: got %02h want 00", rsp_data); end
        n_tests++;
        if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ldi();
        logic [7:0] e;
        run_cmd(2'b01, 3'd0, 3'd3, 8'hA5, 1'b0);
        e = exp_q.pop_front();
        n_tests++;
        if (cyc_we[1] !== 1'b1 || cyc_rn[1] !== 3'd3 || cyc_wd[1] !== 8'hA5) begin
            n_fail++; $display("FAIL ldi_write_c1: we=%0b reg=%0d data=%02h want 1/3/a5", cyc_we[1], cyc_rn[1], cyc_wd[1]);
        end
        n_tests++;
        if (rsp_cnt !== 1 || rsp_at !== 2) begin
            n_fail++; $display("FAIL ldi_latency: rsp at cycle %0d (count %0d) want cycle 2", rsp_at, rsp_cnt);
        end
        n_tests++;
        if (rsp_dat !== e) begin n_fail++; $display("FAIL ldi_data: got %02h want %02h", rsp_dat, e); end
        n_tests++;
        if (obs_rd_n !== 0) begin n_fail++; $display("FAIL ldi_no_read: got %0d reads want 0", obs_rd_n); end
        n_tests++;
        if (rf[3] !== ref_rf[3]) begin n_fail++; $display("FAIL ldi_rf: R3=%02h want %02h", rf[3], ref_rf[3]); end
    endtask

    task automatic test_rd();
        logic [7:0] e;
        run_cmd(2'b11, 3'd3, 3'd0, 8'h00, 1'b0);
        e = exp_q.pop_front();
        n_tests++;
        if (cyc_re[1] !== 1'b1 || cyc_rn[1] !== 3'd3) begin
            n_fail++; $display("FAIL rd_read_c1: re=%0b reg=%0d want 1/3", cyc_re[1], cyc_rn[1]);
        end
        n_tests++;
        if (rsp_cnt !== 1 || rsp_at !== 3) begin
            n_fail++; $display("FAIL rd_latency: rsp at cycle %0d (count %0d) want cycle 3", rsp_at, rsp_cnt);
        end
        n_tests++;
        if (rsp_dat !== e) begin n_fail++; $display("FAIL rd_data: got %02h want %02h", rsp_dat, e); end
        n_tests++;
        if (obs_wr_n !== 0) begin n_fail++; $display("FAIL rd_no_write: got %0d writes want 0", obs_wr_n); end
    endtask

    task automatic test_swap();
        logic [7:0] e;
        run_cmd(2'b01, 3'd0, 3'd1, 8'h11, 1'b0);
        run_cmd(2'b01, 3'd0, 3'd6, 8'h66, 1'b0);
        exp_q.delete();
        run_cmd(2'b10, 3'd1, 3'd6, 8'h00, 1'b0);
        e = exp_q.pop_front();
        n_tests++;
        if (cyc_re[1] !== 1'b1 || cyc_rn[1] !== 3'd1 || cyc_re[3] !== 1'b1 || cyc_rn[3] !== 3'd6) begin
            n_fail++; $display("FAIL swap_reads: c1 re=%0b reg=%0d c3 re=%0b reg=%0d want 1/1 1/6",
                               cyc_re[1], cyc_rn[1], cyc_re[3], cyc_rn[3]);
        end
        n_tests++;
        if (cyc_we[5] !== 1'b1 || cyc_rn[5] !== 3'd6 || cyc_wd[5] !== 8'h11 ||
            cyc_we[6] !== 1'b1 || cyc_rn[6] !== 3'd1 || cyc_wd[6] !== 8'h66) begin
            n_fail++; $display("FAIL swap_writes: c5 %0b/%0d/%02h c6 %0b/%0d/%02h want 1/6/11 1/1/66",
                               cyc_we[5], cyc_rn[5], cyc_wd[5], cyc_we[6], cyc_rn[6], cyc_wd[6]);
        end
        n_tests++;
        if (rsp_cnt !== 1 || rsp_at !== 7) begin
            n_fail++; $display("FAIL swap_latency: rsp at cycle %0d (count %0d) want cycle 7", rsp_at, rsp_cnt);
        end
        n_tests++;
        if (rsp_dat !== e) begin n_fail++; $display("FAIL swap_data: got %02h want %02h", rsp_dat, e); end
        n_tests++;
        if (rf[1] !== ref_rf[1] || rf[6] !== ref_rf[6]) begin
            n_fail++; $display("FAIL swap_rf: R1=%02h R6=%02h want %02h %02h", rf[1], rf[6], ref_rf[1], ref_rf[6]);
        end
    endtask

    task automatic test_mov_busy();
        logic [7:0] e;
        // cmd_valid stays high through the whole MOV
        run_cmd(2'b00, 3'd6, 3'd0, 8'h00, 1'b1);
        e = exp_q.pop_front();
        n_tests++;
        if (rsp_cnt !== 1 || rsp_at !== 4) begin
            n_fail++; $display("FAIL mov_latency: rsp at cycle %0d (count %0d) want cycle 4", rsp_at, rsp_cnt);
        end
        n_tests++;
        if (rsp_dat !== e) begin n_fail++; $display("FAIL mov_data: got %02h want %02h", rsp_dat, e); end
        n_tests++;
        if (obs_rd_n !== 1 || obs_wr_n !== 1) begin
            n_fail++; $display("FAIL mov_single_accept: reads=%0d writes=%0d want 1/1", obs_rd_n, obs_wr_n);
        end
        n_tests++;
        if (busy_bad || !ready_after) begin
            n_fail++; $display("FAIL mov_ready: busy_high=%0b ready_after=%0b want 0/1", busy_bad, ready_after);
        end
        n_tests++;
        if (rf[0] !== ref_rf[0]) begin n_fail++; $display("FAIL mov_rf: R0=%02h want %02h", rf[0], ref_rf[0]); end
        // The held valid now carries the next command, taken once ready returns
        run_cmd(2'b11, 3'd0, 3'd0, 8'h00, 1'b0);
        e = exp_q.pop_front();
        n_tests++;
        if (rsp_cnt !== 1 || rsp_at !== 3 || rsp_dat !== e) begin
            n_fail++; $display("FAIL mov_next_cmd: rsp at %0d data %02h want cycle 3 data %02h", rsp_at, rsp_dat, e);
        end
    endtask

    task automatic test_reset_mid();
        int rsp_seen;
        int waited;
        run_cmd(2'b01, 3'd0, 3'd1, 8'h11, 1'b0);
        run_cmd(2'b01, 3'd0, 3'd6, 8'h5A, 1'b0);
        exp_q.delete();
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
        cmd_op = 2'b10; cmd_src = 3'd1; cmd_dst = 3'd6; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        // Let the WR_A write of R6 land, then abort before WR_B writes R1
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({read_en, write_en, rsp_valid} !== 3'b000 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_outputs: rd/wr/rsp=%03b ready=%0b want 000/1",
                               {read_en, write_en, rsp_valid}, cmd_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        n_tests++;
        if (rsp_seen !== 0) begin n_fail++; $display("FAIL abort_no_rsp: got %0d responses want 0", rsp_seen); end
        ref_rf[6] = ref_rf[1];
        n_tests++;
        if (rf[6] !== 8'h11 || rf[6] !== ref_rf[6]) begin
            n_fail++; $display("FAIL abort_r6: R6=%02h want 11", rf[6]);
        end
        n_tests++;
        if (rf[1] !== ref_rf[1]) begin n_fail++; $display("FAIL abort_r1: R1=%02h want %02h", rf[1], ref_rf[1]); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] ops [6] = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
        logic [2:0] srcs[6] = '{3'd2, 3'd4, 3'd0, 3'd5, 3'd5, 3'd2};
        logic [2:0] dsts[6] = '{3'd2, 3'd4, 3'd5, 3'd0, 3'd2, 3'd7};
        logic [7:0] e;
        for (int i = 0; i < 6; i++) begin
            run_cmd(ops[i], srcs[i], dsts[i], 8'hC3 + 8'(i), 1'b1);
            e = exp_q.pop_front();
            n_tests++;
            if (rsp_cnt !== 1 || rsp_at !== exp_lat || rsp_dat !== e) begin
                n_fail++; $display("FAIL b2b_rsp[%0d]: at %0d cnt %0d data %02h want at %0d data %02h",
                                   i, rsp_at, rsp_cnt, rsp_dat, exp_lat, e);
            end
            n_tests++;
            if (obs_rd_n !== exp_rd_n || obs_rd_sig !== exp_rd_sig ||
                obs_wr_n !== exp_wr_n || obs_wr_sig !== exp_wr_sig) begin
                n_fail++; $display("FAIL b2b_access[%0d]: rd %0d/%h wr %0d/%h want rd %0d/%h wr %0d/%h",
                                   i, obs_rd_n, obs_rd_sig, obs_wr_n, obs_wr_sig,
                                   exp_rd_n, exp_rd_sig, exp_wr_n, exp_wr_sig);
            end
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        for (int r = 0; r < NREG; r++) begin
            n_tests++;
            if (rf[r] !== ref_rf[r]) begin n_fail++; $display("FAIL b2b_rf[%0d]: got %02h want %02h", r, rf[r], ref_rf[r]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] e;
        int gap;
        for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                cmd_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            e = exp_q.pop_front();
            n_tests++;
            if (rsp_cnt !== 1 || rsp_at !== exp_lat) begin
                n_fail++; $display("FAIL rand_latency[%0d]: rsp at %0d cnt %0d want at %0d", i, rsp_at, rsp_cnt, exp_lat);
            end
            n_tests++;
            if (rsp_dat !== e) begin n_fail++; $display("FAIL rand_data[%0d]: got %02h want %02h", i, rsp_dat, e); end
            n_tests++;
            if (obs_rd_n !== exp_rd_n || obs_rd_sig !== exp_rd_sig) begin
                n_fail++; $display("FAIL rand_reads[%0d]: %0d/%h want %0d/%h", i, obs_rd_n, obs_rd_sig, exp_rd_n, exp_rd_sig);
            end
            n_tests++;
            if (obs_wr_n !== exp_wr_n || obs_wr_sig !== exp_wr_sig) begin
                n_fail++; $display("FAIL rand_writes[%0d]: %0d/%h want %0d/%h", i, obs_wr_n, obs_wr_sig, exp_wr_n, exp_wr_sig);
            end
            n_tests++;
            if (busy_bad || !ready_after) begin
                n_fail++; $display("FAIL rand_ready[%0d]: busy_high=%0b ready_after=%0b want 0/1", i, busy_bad, ready_after);
            end
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        for (int r = 0; r < NREG; r++) begin
            n_tests++;
            if (rf[r] !== ref_rf[r]) begin n_fail++; $display("FAIL rand_rf[%0d]: got %02h want %02h", r, rf[r], ref_rf[r]); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_ldi();
        test_rd();
        test_swap();
        test_mov_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
